// File: rtl/ysyx_22050710_mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, widths.
package ysyx_22050710_mdu_pkg;

  localparam int unsigned MDU_XLEN = 64;
  localparam int unsigned CNT_W    = $clog2(MDU_XLEN) + 1;

  // ALUctr op codes, also used by the decode unit
  localparam logic [4:0] ALU_MUL  = 5'b01010;
  localparam logic [4:0] ALU_DIV  = 5'b01011;
  localparam logic [4:0] ALU_DIVU = 5'b01100;
  localparam logic [4:0] ALU_REM  = 5'b01101;
  localparam logic [4:0] ALU_REMU = 5'b01110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_DIVU) ||
           (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22050710_mdu_iter.sv
// Iteration datapath: shift-add multiply or restoring divide, one step per enable.
// x: multiplier (mul) / dividend-then-quotient (div); y: multiplicand / divisor;
// z: accumulator / partial remainder (one guard bit).
module ysyx_22050710_mdu_iter
  import ysyx_22050710_mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            en,
  input  logic            is_div,
  input  logic [XLEN-1:0] init_x,
  input  logic [XLEN-1:0] init_y,
  output logic [XLEN-1:0] quo_c,
  output logic [XLEN-1:0] acc_c
);

  logic [XLEN-1:0] x, y, x_nxt, y_nxt;
  logic [XLEN:0]   z, z_nxt, shifted;
  logic            ge;

  // Next value of the working registers after one iteration
  always_comb begin
    shifted = {z[XLEN-1:0], x[XLEN-1]};
    ge      = shifted >= {1'b0, y};
    x_nxt   = x;
    y_nxt   = y;
    z_nxt   = z;
    if (is_div) begin
      z_nxt = ge ? (shifted - {1'b0, y}) : shifted;
      x_nxt = {x[XLEN-2:0], ge};
    end else begin
      z_nxt = z + (x[0] ? {1'b0, y} : '0);
      x_nxt = x >> 1;
      y_nxt = y << 1;
    end
  end

  assign quo_c = x_nxt;
  assign acc_c = z_nxt[XLEN-1:0];

  // Working registers: load operands at accept, step while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      z <= '0;
    end else if (load) begin
      x <= init_x;
      y <= init_y;
      z <= '0;
    end else if (en) begin
      x <= x_nxt;
      y <= y_nxt;
      z <= z_nxt;
    end
  end

endmodule

// File: rtl/ysyx_22050710_mdu_ctrl.sv
// Multi-cycle multiply/divide controller: handshake, FSM, iteration counter,
// sign pre/post-processing and the single-cycle special cases.
module ysyx_22050710_mdu_ctrl
  import ysyx_22050710_mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_ALUctr,
  input  logic            i_word_cut,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic            i_flush,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             is_div_q, is_rem_q, word_q, q_neg_q, r_neg_q;

  logic            supported, is_div_in, is_rem_in, sdiv_in, uns_in;
  logic [XLEN-1:0] a_ext, b_ext, a_w, a_mag, b_mag, min_val;
  logic            a_neg, b_neg, div_zero, ovf, special, accept, load;
  logic [XLEN-1:0] special_res, init_x, init_y;
  logic [XLEN-1:0] quo_c, acc_c, res_raw, res_fix, calc_res;
  logic            res_neg, iter_en;

  // Request decode and operand preparation at accept time
  always_comb begin
    supported = is_mdu_op(i_ALUctr);
    is_div_in = (i_ALUctr != ALU_MUL);
    is_rem_in = (i_ALUctr == ALU_REM) || (i_ALUctr == ALU_REMU);
    sdiv_in   = (i_ALUctr == ALU_DIV) || (i_ALUctr == ALU_REM);
    uns_in    = (i_ALUctr == ALU_DIVU) || (i_ALUctr == ALU_REMU);
    a_w       = i_word_cut ? sext32(i_src_a[31:0]) : i_src_a;
    a_ext     = (i_word_cut && uns_in) ? {32'b0, i_src_a[31:0]} : a_w;
    b_ext     = i_word_cut ? (uns_in ? {32'b0, i_src_b[31:0]} : sext32(i_src_b[31:0]))
                           : i_src_b;
    a_neg     = sdiv_in & a_ext[XLEN-1];
    b_neg     = sdiv_in & b_ext[XLEN-1];
    a_mag     = a_neg ? -a_ext : a_ext;
    b_mag     = b_neg ? -b_ext : b_ext;
    min_val   = i_word_cut ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero  = is_div_in && (b_ext == '0);
    ovf       = sdiv_in && (a_ext == min_val) && (b_ext == '1);
    special   = div_zero | ovf;
    // Divide by zero: q = -1, r = A.  Overflow: q = A, r = 0.
    special_res = div_zero ? (is_rem_in ? a_w : '1) : (is_rem_in ? '0 : a_w);
    // W divides start the dividend in the upper half so 32 shifts consume it
    init_x    = is_div_in ? (i_word_cut ? {a_mag[31:0], 32'b0} : a_mag) : b_ext;
    init_y    = is_div_in ? b_mag : a_ext;
    accept    = i_valid & o_ready & ~i_flush & supported & (state == ST_IDLE);
    load      = accept & ~special;
    iter_en   = (state == ST_CALC) & ~i_flush;
  end

  ysyx_22050710_mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .load   (load),
    .en     (iter_en),
    .is_div (is_div_q),
    .init_x (init_x),
    .init_y (init_y),
    .quo_c  (quo_c),
    .acc_c  (acc_c)
  );

  // Sign correction and W sign-extension of the post-final-iteration value
  always_comb begin
    res_raw  = (is_div_q && !is_rem_q) ? quo_c : acc_c;
    res_neg  = is_div_q && (is_rem_q ? r_neg_q : q_neg_q);
    res_fix  = res_neg ? -res_raw : res_raw;
    calc_res = word_q ? sext32(res_fix[31:0]) : res_fix;
  end

  // Control FSM with registered handshake outputs and result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      o_ready     <= 1'b1;
      o_busy      <= 1'b0;
      o_out_valid <= 1'b0;
      o_result    <= '0;
      is_div_q    <= 1'b0;
      is_rem_q    <= 1'b0;
      word_q      <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            is_div_q <= is_div_in;
            is_rem_q <= is_rem_in;
            word_q   <= i_word_cut;
            q_neg_q  <= a_neg ^ b_neg;
            r_neg_q  <= a_neg;
            o_ready  <= 1'b0;
            o_busy   <= 1'b1;
            if (special) begin
              state       <= ST_DONE;
              cnt         <= '0;
              o_out_valid <= 1'b1;
              o_result    <= special_res;
            end else begin
              state <= ST_CALC;
              cnt   <= i_word_cut ? CNT_W'(32) : CNT_W'(64);
            end
          end
        end
        ST_CALC: begin
          if (i_flush) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state       <= ST_DONE;
              o_out_valid <= 1'b1;
              o_result    <= calc_res;
            end
          end
        end
        ST_DONE: begin
          if (i_flush) begin
            state       <= ST_IDLE;
            o_ready     <= 1'b1;
            o_busy      <= 1'b0;
            o_out_valid <= 1'b0;
            o_result    <= '0;
          end else if (i_out_ready) begin
            state       <= ST_IDLE;
            o_ready     <= 1'b1;
            o_busy      <= 1'b0;
            o_out_valid <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          cnt         <= '0;
          o_ready     <= 1'b1;
          o_busy      <= 1'b0;
          o_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_mdu_ctrl.sv
// Scoreboard testbench for the multiply/divide controller.
module tb_ysyx_22050710_mdu_ctrl;

  localparam logic [4:0] OP_MUL  = 5'b01010;
  localparam logic [4:0] OP_DIV  = 5'b01011;
  localparam logic [4:0] OP_DIVU = 5'b01100;
  localparam logic [4:0] OP_REM  = 5'b01101;
  localparam logic [4:0] OP_REMU = 5'b01110;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_valid, i_word_cut, i_flush, i_out_ready;
  logic [4:0]  i_ALUctr;
  logic [63:0] i_src_a, i_src_b, o_result;
  logic        o_ready, o_out_valid, o_busy;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 i_clk = ~i_clk;

  ysyx_22050710_mdu_ctrl #(.XLEN(64)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_ALUctr    (i_ALUctr),
    .i_word_cut  (i_word_cut),
    .i_src_a     (i_src_a),
    .i_src_b     (i_src_b),
    .i_flush     (i_flush),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_result    (o_result),
    .o_busy      (o_busy)
  );

  // Reference model built from the language's own arithmetic operators
  function automatic exp_t model(input logic [4:0] op, input bit word,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [31:0] a32, b32, r32;
    logic signed [31:0] sa32, sb32;
    logic [63:0] r;
    logic signed [63:0] sa, sb;
    bit spec;
    spec = 0;
    a32 = a[31:0]; b32 = b[31:0]; sa32 = a[31:0]; sb32 = b[31:0];
    sa = a; sb = b;
    r32 = '0; r = '0;
    if (word) begin
      case (op)
        OP_MUL:  r32 = a32 * b32;
        OP_DIV:  if (b32 == 0) begin r32 = '1; spec = 1; end
                 else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin r32 = a32; spec = 1; end
                 else r32 = sa32 / sb32;
        OP_REM:  if (b32 == 0) begin r32 = a32; spec = 1; end
                 else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin r32 = '0; spec = 1; end
                 else r32 = sa32 % sb32;
        OP_DIVU: if (b32 == 0) begin r32 = '1; spec = 1; end else r32 = a32 / b32;
        default: if (b32 == 0) begin r32 = a32; spec = 1; end else r32 = a32 % b32;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (op)
        OP_MUL:  r = a * b;
        OP_DIV:  if (b == 0) begin r = '1; spec = 1; end
                 else if (a == 64'h8000_0000_0000_0000 && b == '1) begin r = a; spec = 1; end
                 else r = sa / sb;
        OP_REM:  if (b == 0) begin r = a; spec = 1; end
                 else if (a == 64'h8000_0000_0000_0000 && b == '1) begin r = '0; spec = 1; end
                 else r = sa % sb;
        OP_DIVU: if (b == 0) begin r = '1; spec = 1; end else r = a / b;
        default: if (b == 0) begin r = a; spec = 1; end else r = a % b;
      endcase
    end
    e.res = r;
    e.lat = spec ? 1 : (word ? 33 : 65);
    return e;
  endfunction

  // Drive one request cycle (entered at a negedge with o_ready high)
  task automatic issue(input logic [4:0] op, input bit word, input logic [63:0] a,
                       input logic [63:0] b, input bit track);
    i_valid = 1'b1; i_ALUctr = op; i_word_cut = word; i_src_a = a; i_src_b = b;
    if (track) exp_q.push_back(model(op, word, a, b));
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  // Wait (bounded) for o_out_valid, capture result and latency, then retire
  task automatic collect(output logic [63:0] res, output int lat, output bit to);
    lat = 1;
    while (o_out_valid !== 1'b1 && lat < 200) begin
      @(negedge i_clk);
      lat++;
    end
    to  = (o_out_valid !== 1'b1);
    res = o_result;
    i_out_ready = 1'b1;
    @(negedge i_clk);
    i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_ALUctr = '0; i_word_cut = 1'b0;
    i_src_a = '0; i_src_b = '0; i_flush = 1'b0; i_out_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_out_valid !== 1'b0 || o_result !== 64'd0) begin
      failures++;
      $display("FAIL reset_state actual ready=%b busy=%b valid=%b result=%h required 1 0 0 0",
               o_ready, o_busy, o_out_valid, o_result);
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [63:0] res; int lat; bit to; exp_t e;
    issue(OP_MUL, 0, 64'd7, -64'sd3, 1);
    collect(res, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || lat != e.lat || lat != 65) begin
      failures++; $display("FAIL mul_latency actual=%0d required=65", lat);
    end
    checks++;
    if (res !== e.res || res !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      failures++; $display("FAIL mul_result actual=%h required=%h", res, 64'hFFFF_FFFF_FFFF_FFEB);
    end
  endtask

  task automatic test_divw_remw();
    logic [63:0] res; int lat; bit to; exp_t e;
    logic [4:0] ops [2];
    logic [63:0] want [2];
    ops[0] = OP_DIV; ops[1] = OP_REM;
    want[0] = 64'hFFFF_FFFF_FFFF_FFFA; want[1] = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 1, -64'sd20, 64'd3, 1);
      collect(res, lat, to);
      e = exp_q.pop_front();
      checks++;
      if (to || lat != e.lat || lat != 33) begin
        failures++; $display("FAIL w_latency[%0d] actual=%0d required=33", i, lat);
      end
      checks++;
      if (res !== e.res || res !== want[i]) begin
        failures++; $display("FAIL w_result[%0d] actual=%h required=%h", i, res, want[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [63:0] res; int lat; bit to; exp_t e;
    logic [4:0] ops [4];
    logic [63:0] as [4];
    logic [63:0] bs [4];
    logic [63:0] want [4];
    ops[0] = OP_DIVU; as[0] = 64'd5; bs[0] = 64'd0; want[0] = '1;
    ops[1] = OP_REMU; as[1] = 64'd5; bs[1] = 64'd0; want[1] = 64'd5;
    ops[2] = OP_DIV;  as[2] = 64'h8000_0000_0000_0000; bs[2] = '1; want[2] = 64'h8000_0000_0000_0000;
    ops[3] = OP_REM;  as[3] = 64'h8000_0000_0000_0000; bs[3] = '1; want[3] = 64'd0;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 0, as[i], bs[i], 1);
      collect(res, lat, to);
      e = exp_q.pop_front();
      checks++;
      if (to || lat != e.lat || lat != 1) begin
        failures++; $display("FAIL special_latency[%0d] actual=%0d required=1", i, lat);
      end
      checks++;
      if (res !== e.res || res !== want[i]) begin
        failures++; $display("FAIL special_result[%0d] actual=%h required=%h", i, res, want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] res; int lat; bit to; exp_t e;
    bit bad;
    issue(OP_MUL, 0, 64'd3, 64'd4, 1);
    lat = 1;
    while (o_out_valid !== 1'b1 && lat < 200) begin
      @(negedge i_clk);
      lat++;
    end
    e = exp_q.pop_front();
    checks++;
    if (o_out_valid !== 1'b1 || lat != e.lat) begin
      failures++; $display("FAIL bp_latency actual=%0d required=%0d", lat, e.lat);
    end
    for (int i = 0; i < 10; i++) begin
      bad = (o_result !== e.res) || (o_out_valid !== 1'b1) || (o_ready !== 1'b0) || (o_busy !== 1'b1);
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL bp_hold[%0d] actual result=%h valid=%b ready=%b required result=%h valid=1 ready=0",
                 i, o_result, o_out_valid, o_ready, e.res);
      end
      @(negedge i_clk);
    end
    // Retire and present a new request in the same cycle: must not be taken
    i_out_ready = 1'b1;
    i_valid = 1'b1; i_ALUctr = OP_DIVU; i_word_cut = 1'b0; i_src_a = 64'd100; i_src_b = 64'd7;
    @(negedge i_clk);
    i_out_ready = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_retire actual ready=%b busy=%b valid=%b required 1 0 0", o_ready, o_busy, o_out_valid);
    end
    exp_q.push_back(model(OP_DIVU, 0, 64'd100, 64'd7));
    @(negedge i_clk);
    i_valid = 1'b0;
    collect(res, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || lat != e.lat || res !== e.res || res !== 64'd14) begin
      failures++; $display("FAIL bp_next actual=%h lat=%0d required=%h lat=%0d", res, lat, e.res, e.lat);
    end
  endtask

  task automatic test_flush();
    logic [63:0] res; int lat; bit to; exp_t e;
    bit seen;
    issue(OP_MUL, 0, 64'h1234_5678, 64'h9ABC_DEF0, 0);
    repeat (19) @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_calc actual busy=%b ready=%b valid=%b required 0 1 0", o_busy, o_ready, o_out_valid);
    end
    seen = 0;
    repeat (80) begin
      @(negedge i_clk);
      if (o_out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL flush_no_valid actual=1 required=0");
    end
    // Flush in IDLE blocks the simultaneous request
    i_valid = 1'b1; i_flush = 1'b1; i_ALUctr = OP_DIVU; i_src_a = 64'd9; i_src_b = 64'd2;
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
      failures++; $display("FAIL flush_idle actual busy=%b ready=%b required 0 1", o_busy, o_ready);
    end
    // Flush beats out_ready in DONE
    issue(OP_DIVU, 0, 64'd5, 64'd0, 0);
    i_flush = 1'b1; i_out_ready = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0; i_out_ready = 1'b0;
    checks++;
    if (o_out_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 64'd0) begin
      failures++;
      $display("FAIL flush_done actual valid=%b ready=%b result=%h required 0 1 0", o_out_valid, o_ready, o_result);
    end
    issue(OP_DIV, 0, 64'd100, 64'd7, 1);
    collect(res, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || lat != e.lat || res !== e.res || res !== 64'd14) begin
      failures++; $display("FAIL flush_next actual=%h lat=%0d required=%h lat=%0d", res, lat, e.res, e.lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res; int lat; bit to; exp_t e;
    issue(OP_DIV, 0, 64'd1000, 64'd3, 0);
    repeat (10) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_out_valid !== 1'b0 || o_result !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid actual ready=%b busy=%b valid=%b result=%h required 1 0 0 0",
               o_ready, o_busy, o_out_valid, o_result);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    issue(OP_DIV, 0, 64'd100, 64'd7, 1);
    collect(res, lat, to);
    e = exp_q.pop_front();
    checks++;
    if (to || lat != e.lat || res !== e.res || res !== 64'd14) begin
      failures++; $display("FAIL reset_next actual=%h lat=%0d required=%h lat=%0d", res, lat, e.res, e.lat);
    end
  endtask

  task automatic test_unsupported();
    logic [4:0] bad_ops [3];
    bad_ops[0] = 5'b00000; bad_ops[1] = 5'b01001; bad_ops[2] = 5'b01111;
    for (int i = 0; i < 3; i++) begin
      issue(bad_ops[i], 0, 64'd10, 64'd2, 0);
      checks++;
      if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL unsupported[%0d] actual busy=%b ready=%b required 0 1", i, o_busy, o_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res, a, b; int lat; bit to; exp_t e;
    logic [4:0] ops [5];
    logic [4:0] op;
    bit word;
    ops[0] = OP_MUL; ops[1] = OP_DIV; ops[2] = OP_DIVU; ops[3] = OP_REM; ops[4] = OP_REMU;
    for (int i = 0; i < 16; i++) begin
      op   = ops[$urandom_range(0, 4)];
      word = 1'($urandom_range(0, 1));
      a    = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 50));
        2: b = '1;
        3: b = -64'($urandom_range(1, 50));
        default: b = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 5) == 0) a = word ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
      issue(op, word, a, b, 1);
      collect(res, lat, to);
      e = exp_q.pop_front();
      checks++;
      if (to || lat != e.lat || res !== e.res) begin
        failures++;
        $display("FAIL b2b[%0d] op=%b w=%0d a=%h b=%h actual=%h lat=%0d required=%h lat=%0d",
                 i, op, word, a, b, res, lat, e.res, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_divw_remw();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_unsupported();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_mdu_ctrl.md
YSYX_22050710_MDU_CTRL -- requirements
Module: ysyx_22050710_mdu_ctrl

Interface
REQ-001 Parameter XLEN, default 64, datapath width; only 64 is supported.
REQ-002 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_valid  in  1  operation request from the execute stage.
REQ-005 o_ready  out  1  controller can accept a request.
REQ-006 i_ALUctr  in  5  op code: 01010 mul, 01011 div, 01100 divu, 01101 rem, 01110 remu; other codes are ignored.
REQ-007 i_word_cut  in  1  W-variant: 32-bit operation, result sign-extended.
REQ-008 i_src_a, i_src_b  in  64  operand A (dividend/multiplicand), operand B.
REQ-009 i_flush  in  1  kill the in-flight operation (pipeline redirect).
REQ-010 o_out_valid  out  1  result available.
REQ-011 i_out_ready  in  1  consumer accepts the result.
REQ-012 o_result  out  64  final result.
REQ-013 o_busy  out  1  high in CALC or DONE; used by the hazard unit to stall.

Function
REQ-014 FSM states are IDLE, CALC and DONE.
REQ-015 IDLE to CALC on i_valid & o_ready with a supported code; a div-by-zero or signed overflow request goes IDLE to DONE instead.
REQ-016 CALC to DONE when the iteration counter reaches 0 after its final iteration; DONE to IDLE on i_out_ready.
REQ-017 o_ready = 1 only in IDLE; requests with an unsupported i_ALUctr are dropped and the FSM stays in IDLE.
REQ-018 Iteration count N = 64 when i_word_cut=0 and N = 32 when i_word_cut=1.
REQ-019 The counter loads N at accept and decrements once per CALC cycle.
REQ-020 o_out_valid first goes high exactly N+1 cycles after the accept edge.
REQ-021 o_out_valid and o_result hold stable in DONE until i_out_ready; o_out_valid is high only in DONE.
REQ-022 Multiply is shift-add, one partial-product bit per cycle; the result is the low XLEN bits (low 32 bits for a W op).
REQ-023 Divide is restoring radix-2, one quotient bit per cycle, on magnitudes; signs are corrected in the final CALC cycle.
REQ-024 Signed ops take absolute values at accept.
REQ-025 Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
REQ-026 W ops use A[31:0] and B[31:0], sign-extended for mul/div/rem and zero-extended for divu/remu; result = sign-extended bit 31 of the 32-bit result.
REQ-027 Divide by zero: quotient = all ones (64-bit, or 32-bit sign-extended), remainder = A (W: sign-extended A[31:0]); latency 1 cycle.
REQ-028 Signed overflow (A = most negative value, B = -1, at the operation width): quotient = A, remainder = 0; latency 1 cycle.
REQ-029 i_flush in CALC or DONE returns the FSM to IDLE next cycle, drops o_out_valid and discards the result.
REQ-030 i_flush in IDLE blocks acceptance in that cycle.
REQ-031 i_flush has priority over a simultaneous i_out_ready or accept.
REQ-032 A new request is not accepted in the same cycle that DONE is retired; the earliest accept is the following cycle, in IDLE.

Reset
REQ-033 Asserting i_rst_n low drives state to IDLE, the counter to 0 and o_out_valid to 0 immediately, regardless of the clock.
REQ-034 During reset o_ready = 1 (in IDLE), o_busy = 0 and o_result = 0.
REQ-035 Reset mid-operation discards all partial results.
REQ-036 The first accept is possible on the first rising edge after deassertion.

Structure
REQ-037 A shared package holds the ALUctr op-code constants (01010 to 01110), the FSM state enumeration and XLEN.
REQ-038 The ALUctr op-code constants are reused by the decode unit.
REQ-039 One sub-module, ysyx_22050710_mdu_iter, holds the shift/accumulate registers and performs one iteration per enable.
REQ-040 ysyx_22050710_mdu_ctrl owns the FSM, counter, handshake, sign pre/post-processing and special cases.

Verification
REQ-041 mul, A=7, B=-3, word_cut=0 -> o_out_valid at cycle 65 after accept, o_result = 0xFFFFFFFFFFFFFFEB.
REQ-042 divw, A=-20, B=3 -> valid at cycle 33, o_result = 0xFFFFFFFFFFFFFFFA; remw with the same operands -> 0xFFFFFFFFFFFFFFFE.
REQ-043 divu, B=0, A=5 -> valid at cycle 1, o_result = all ones; remu with the same operands -> 5.
REQ-044 div, A=0x8000000000000000, B=-1 -> valid at cycle 1, o_result = 0x8000000000000000; rem with the same operands -> 0.
REQ-045 mul, A=3, B=4, i_out_ready held 0 for 10 cycles after valid -> o_result = 12 stable and o_ready = 0 throughout; accept at the cycle after i_out_ready = 1.
REQ-046 i_flush at CALC cycle 20 (one run); i_rst_n pulsed low mid-CALC (separate run) -> IDLE next cycle, o_out_valid never rises, and a following div 100/7 returns 14.
